// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage: turns fetched words into ALU control, immediate and operand selects,
// registered at the ID/EX boundary behind a 2-entry skid buffer (or a single entry).
module alu_ctrl_decode #(
  parameter int XLEN    = 32,
  parameter bit EN_SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_use_pc,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_AND    = 4'd4;
  localparam logic [3:0] ALU_OR     = 4'd5;
  localparam logic [3:0] ALU_XOR    = 4'd6;
  localparam logic [3:0] ALU_SRL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        illegal;
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    logic [3:0] a;
    case (f3)
      3'b000:  a = ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = ALU_SRL;
      3'b110:  a = ALU_OR;
      3'b111:  a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t      d;
    logic        bad;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'h000};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    shamt = {27'd0, instr[24:20]};
    d       = '0;
    d.instr = instr;
    d.pc    = pc;
    bad     = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          d.alu = f3_alu(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.alu = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          d.alu = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        d.use_imm = 1'b1;
        d.alu     = f3_alu(f3);
        // shift immediates carry only the shamt; instr[31:25] picks the shift flavour
        if (f3 == 3'b001) begin
          d.imm = shamt;
          bad   = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          d.imm = shamt;
          if (f7 == 7'b0000000) begin
            d.alu = ALU_SRL;
          end else if (f7 == 7'b0100000) begin
            d.alu = ALU_SRA;
          end else begin
            bad = 1'b1;
          end
        end else begin
          d.imm = imm_i;
        end
      end
      OPC_LUI:   begin d.alu = ALU_PASS_B; d.use_imm = 1'b1; d.imm = imm_u; end
      OPC_AUIPC: begin d.use_pc = 1'b1; d.use_imm = 1'b1; d.imm = imm_u; end
      OPC_LOAD:  begin d.use_imm = 1'b1; d.imm = imm_i; end
      OPC_STORE: begin d.use_imm = 1'b1; d.imm = imm_s; end
      OPC_BRANCH: begin
        d.imm = imm_b;
        case (f3)
          3'b000, 3'b001: d.alu = ALU_SUB;
          3'b100, 3'b101: d.alu = ALU_SLT;
          3'b110, 3'b111: d.alu = ALU_SLTU;
          default:        bad   = 1'b1;
        endcase
      end
      OPC_JAL:   begin d.use_pc = 1'b1; d.use_imm = 1'b1; d.imm = imm_j; end
      OPC_JALR:  begin d.use_imm = 1'b1; d.imm = imm_i; bad = (f3 != 3'b000); end
      default:   bad = 1'b1;
    endcase
    if (bad) begin
      d.alu     = ALU_ADD;
      d.imm     = 32'h0000_0000;
      d.use_imm = 1'b0;
      d.use_pc  = 1'b0;
      d.illegal = 1'b1;
    end else begin
      d.illegal = 1'b0;
    end
    return d;
  endfunction

  state_t state_r, state_s;
  entry_t m_r, m_s, s_r, s_s, dec_s;
  logic   in_ready_r, out_valid_r;
  logic   in_xfer_s, out_xfer_s;

  assign in_ready   = EN_SKID ? in_ready_r : (!out_valid_r || out_ready);
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = out_valid_r && out_ready;

  // decode and buffer next-state; with EN_SKID=0 the FULL state is unreachable
  always_comb begin
    dec_s   = decode(in_instr, in_pc);
    state_s = state_r;
    m_s     = m_r;
    s_s     = s_r;
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            m_s     = dec_s;
            state_s = ST_ONE;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            m_s = dec_s;
          end else if (in_xfer_s) begin
            s_s     = dec_s;
            state_s = ST_FULL;
          end else if (out_xfer_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            m_s     = s_r;
            state_s = ST_ONE;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: state_s = ST_EMPTY;
      endcase
    end
  end

  // state, entries and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      m_r         <= '0;
      s_r         <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      m_r         <= m_s;
      s_r         <= s_s;
      out_valid_r <= (state_s != ST_EMPTY);
      in_ready_r  <= (state_s != ST_FULL);
    end
  end

  assign out_valid    = out_valid_r;
  assign out_alu_ctrl = m_r.alu;
  assign out_imm      = m_r.imm;
  assign out_use_imm  = m_r.use_imm;
  assign out_use_pc   = m_r.use_pc;
  assign out_illegal  = m_r.illegal;
  assign out_instr    = m_r.instr;
  assign out_pc       = m_r.pc;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Self-checking bench: one skid-buffer instance and one single-entry instance share stimulus,
// each scored every cycle against a queue-based model of the decode rules.
module tb_alu_ctrl_decode;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        illegal;
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready1, out_ready0;
  logic [31:0] in_instr, in_pc;
  logic        ir1, ov1, ui1, up1, il1, ir0, ov0, ui0, up0, il0;
  logic [3:0]  alu1, alu0;
  logic [31:0] imm1, oi1, op1, imm0, oi0, op0;
  ent_t        got1, got0;
  ent_t        q1[$];
  ent_t        q0[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  alu_ctrl_decode #(.XLEN(32), .EN_SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov1), .out_ready(out_ready1),
    .out_alu_ctrl(alu1), .out_imm(imm1), .out_use_imm(ui1), .out_use_pc(up1),
    .out_illegal(il1), .out_instr(oi1), .out_pc(op1));

  alu_ctrl_decode #(.XLEN(32), .EN_SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov0), .out_ready(out_ready0),
    .out_alu_ctrl(alu0), .out_imm(imm0), .out_use_imm(ui0), .out_use_pc(up0),
    .out_illegal(il0), .out_instr(oi0), .out_pc(op0));

  assign got1 = {alu1, imm1, ui1, up1, il1, oi1, op1};
  assign got0 = {alu0, imm0, ui0, up0, il0, oi0, op0};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // reference decode written from the instruction-set rules
  function automatic ent_t model(input logic [31:0] w, input logic [31:0] pc);
    ent_t              e;
    logic [6:0]        op, f7;
    logic [2:0]        f3;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic [3:0]        rmap [8];
    bit                bad;
    rmap = '{4'd0, 4'd2, 4'd3, 4'd9, 4'd6, 4'd7, 4'd5, 4'd4};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    i12 = w[31:20];
    s12 = {w[31:25], w[11:7]};
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    e = '0; e.instr = w; e.pc = pc; bad = 1'b0;
    if (op == 7'h33) begin
      if (f7 == 7'h00) e.alu = rmap[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
      else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd8;
      else bad = 1'b1;
    end else if (op == 7'h13) begin
      e.use_imm = 1'b1; e.imm = 32'(i12); e.alu = rmap[f3];
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = {27'd0, w[24:20]};
        if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd8;
        else if (f7 != 7'h00) bad = 1'b1;
      end
    end else if (op == 7'h37) begin
      e.alu = 4'd10; e.use_imm = 1'b1; e.imm = w & 32'hFFFF_F000;
    end else if (op == 7'h17) begin
      e.use_pc = 1'b1; e.use_imm = 1'b1; e.imm = w & 32'hFFFF_F000;
    end else if (op == 7'h03) begin
      e.use_imm = 1'b1; e.imm = 32'(i12);
    end else if (op == 7'h23) begin
      e.use_imm = 1'b1; e.imm = 32'(s12);
    end else if (op == 7'h63) begin
      e.imm = 32'(b13);
      if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
      else e.alu = (f3 < 3'd4) ? 4'd1 : ((f3 < 3'd6) ? 4'd3 : 4'd9);
    end else if (op == 7'h6F) begin
      e.use_pc = 1'b1; e.use_imm = 1'b1; e.imm = 32'(j21);
    end else if (op == 7'h67) begin
      e.use_imm = 1'b1; e.imm = 32'(i12);
      if (f3 != 3'd0) bad = 1'b1;
    end else begin
      bad = 1'b1;
    end
    if (bad) begin
      e.alu = 4'd0; e.imm = 32'd0; e.use_imm = 1'b0; e.use_pc = 1'b0; e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // per-cycle scoreboard: queue occupancy gives valid/ready, queue head gives data
  always @(negedge clk) begin : scoreboard
    bit v1, r1, v0, r0;
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      v1 = (q1.size() > 0);
      r1 = (q1.size() < 2);
      v0 = (q0.size() > 0);
      r0 = !v0 || out_ready0;
      chk("sb1_valid", 128'(ov1), 128'(v1));
      chk("sb1_ready", 128'(ir1), 128'(r1));
      if (v1) chk("sb1_data", 128'(got1), 128'(q1[0]));
      chk("sb0_valid", 128'(ov0), 128'(v0));
      chk("sb0_ready", 128'(ir0), 128'(r0));
      if (v0) chk("sb0_data", 128'(got0), 128'(q0[0]));
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (v1 && out_ready1) void'(q1.pop_front());
        if (in_valid && r1) q1.push_back(model(in_instr, in_pc));
        if (v0 && out_ready0) void'(q0.pop_front());
        if (in_valid && r0) q0.push_back(model(in_instr, in_pc));
      end
    end
  end

  initial begin
    out_ready0 = 1'b0;
    forever begin
      @(posedge clk);
      #1 out_ready0 = ~out_ready0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_instr = w; in_pc = pc_ctr; pc_ctr += 32'd4; in_valid = 1'b1;
    while (!ir1 && n < 20) begin
      step();
      n++;
    end
    chk("send_accept", 128'(ir1), 128'(1'b1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [31:0] w, input logic [3:0] alu, input logic [31:0] imm,
                          input logic ui, input logic up, input logic il);
    ent_t e;
    in_pc = pc_ctr; pc_ctr += 32'd4;
    e = {alu, imm, ui, up, il, w, in_pc};
    chk($sformatf("pin_%h", w), 128'(model(w, in_pc)), 128'(e));
    in_instr = w; in_valid = 1'b1; out_ready1 = 1'b1;
    step();
    in_valid = 1'b0;
    chk($sformatf("dir_valid_%h", w), 128'(ov1), 128'(1'b1));
    chk($sformatf("dir_out_%h", w), 128'(got1), 128'(e));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready1 = 1'b1;
    in_instr = 32'd0; in_pc = 32'd0;
    #2;
    chk("rst_valid", 128'(ov1), 128'(1'b0));
    chk("rst_ready", 128'(ir1), 128'(1'b1));
    chk("rst_data", 128'(got1), 128'(0));
    chk("rst_ready0", 128'(ir0), 128'(1'b1));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    directed(32'h002081B3, 4'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0);
    directed(32'h402081B3, 4'd1,  32'h0000_0000, 1'b0, 1'b0, 1'b0);
    directed(32'h40315093, 4'd8,  32'h0000_0003, 1'b1, 1'b0, 1'b0);
    directed(32'h123452B7, 4'd10, 32'h1234_5000, 1'b1, 1'b0, 1'b0);
    directed(32'h0020E463, 4'd9,  32'h0000_0008, 1'b0, 1'b0, 1'b0);
    directed(32'hFFFFFFFF, 4'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1);
    directed(32'h00001097, 4'd0,  32'h0000_1000, 1'b1, 1'b1, 1'b0);
    directed(32'hFFC12083, 4'd0,  32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    directed(32'hFE20AC23, 4'd0,  32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    step();
    step();

    // back-pressure: A and B fill the buffer, C stalls, then all drain in order
    out_ready1 = 1'b0;
    send(32'h00A00093);
    send(32'h00B00113);
    in_instr = 32'h00C00193; in_pc = pc_ctr; in_valid = 1'b1;
    chk("bp_stall_ready", 128'(ir1), 128'(1'b0));
    chk("bp_hold_a", 128'(oi1), 128'(32'h00A00093));
    step();
    step();
    chk("bp_hold_a2", 128'(oi1), 128'(32'h00A00093));
    chk("bp_stall_ready2", 128'(ir1), 128'(1'b0));
    out_ready1 = 1'b1;
    step();
    chk("bp_out_b", 128'(oi1), 128'(32'h00B00113));
    step();
    chk("bp_out_c", 128'(oi1), 128'(32'h00C00193));
    in_valid = 1'b0;
    step();
    chk("bp_drained", 128'(ov1), 128'(1'b0));

    // flush while FULL, then flush while ONE with an acceptable input
    out_ready1 = 1'b0;
    send(32'h00D00213);
    send(32'h00E00293);
    in_instr = 32'h00F00313; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 128'(ov1), 128'(1'b0));
    chk("flush_ready", 128'(ir1), 128'(1'b1));
    out_ready1 = 1'b1;
    repeat (3) step();
    chk("flush_gone", 128'(ov1), 128'(1'b0));
    out_ready1 = 1'b0;
    send(32'h01000393);
    in_instr = 32'h01100413; in_valid = 1'b1; flush = 1'b1;
    chk("flush1_ready", 128'(ir1), 128'(1'b1));
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", 128'(ov1), 128'(1'b0));

    // asynchronous reset between edges
    send(32'h01200493);
    chk("prerst_valid", 128'(ov1), 128'(1'b1));
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(ov1), 128'(1'b0));
    chk("arst_ready", 128'(ir1), 128'(1'b1));
    chk("arst_data", 128'(got1), 128'(0));
    chk("arst_valid0", 128'(ov0), 128'(1'b0));
    @(posedge clk);
    #1 rst = 1'b0;
    directed(32'h002081B3, 4'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // randomized traffic, scored by the per-cycle model
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_instr   = rand_instr();
      in_pc      = $urandom;
      out_ready1 = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready1 = 1'b1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
- Pipelined decode stage that produces the 4-bit ALU control code and the operand-select and immediate signals consumed by the execute-stage ALU.
- Accepts fetched RV32I instruction words with their PC over a valid/ready handshake.
- Decodes each word and presents the result, registered, to the ID/EX boundary over a second valid/ready handshake.
- A 2-entry skid buffer decouples fetch from execute back-pressure.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- EN_SKID, 1.
  - 1: 2-entry buffer, and in_ready is a pure register output.
  - 0: single entry, and in_ready = !out_valid || out_ready.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  instruction word is valid
- in_ready  output  1  stage can accept a word
- in_instr  input  32  instruction word
- in_pc  input  32  PC of the instruction
- out_valid  output  1  decoded entry is valid
- out_ready  input  1  execute stage accepts the entry
- out_alu_ctrl  output  4  ALU code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 AND, 5 OR, 6 XOR, 7 SRL, 8 SRA, 9 SLTU, 10 PASS_B
- out_imm  output  32  sign-extended immediate
- out_use_imm  output  1  ALU operand B = imm (otherwise rs2)
- out_use_pc  output  1  ALU operand A = pc (otherwise rs1)
- out_illegal  output  1  word is not a supported RV32I instruction
- out_instr  output  32  pass-through copy of the word
- out_pc  output  32  pass-through copy of the PC

Behaviour:
- Reset (asynchronous, rst=1):
  - Both entries are emptied.
  - out_valid=0 and in_ready=1.
  - All data outputs are 0.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Latency: a word accepted in cycle N is visible on the outputs in cycle N+1 if the stage was empty.
- Buffer with EN_SKID=1 (main register M drives the outputs, skid register S):
  - State EMPTY: an input transfer loads M and goes to ONE.
  - State ONE:
    - Input transfer together with output transfer: reload M and stay in ONE.
    - Input transfer only: load S and go to FULL.
    - Output transfer only: go to EMPTY.
  - State FULL (in_ready=0): an output transfer moves S into M and goes to ONE.
  - in_ready = (state != FULL), and is registered.
- Ordering: entries leave in the order they were accepted.
- out_valid must not depend combinationally on out_ready.
- Output data is stable while out_valid && !out_ready.
- flush:
  - Moves to EMPTY on the next edge.
  - Overrides any input transfer in the same cycle; that input word is dropped.
  - in_ready=1 on the following cycle.
- Decode (pure function of in_instr, captured at load):
  - OP 0110011 (R-type):
    - funct7 0000000 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, selected by funct3.
    - funct7 0100000 with funct3 000 → SUB; with funct3 101 → SRA.
    - Any other funct7 → illegal.
  - OP-IMM 0010011: same mapping as OP, with use_imm=1 and the I-type immediate.
    - SLLI requires instr[31:25]=0000000.
    - SRLI/SRAI require instr[31:25] = 0000000 or 0100000, which selects SRL or SRA.
    - For shifts, imm = {27'b0, instr[24:20]}.
  - LUI 0110111: PASS_B, use_imm=1, imm = {instr[31:12], 12'b0}.
  - AUIPC 0010111: ADD, use_pc=1, use_imm=1, U-type immediate.
  - LOAD 0000011: ADD, use_imm=1, I-type immediate.
  - STORE 0100011: ADD, use_imm=1, S-type immediate.
  - BRANCH 1100011 (use_imm=0, B-type immediate passed through):
    - funct3 000/001 → SUB.
    - funct3 100/101 → SLT.
    - funct3 110/111 → SLTU.
    - funct3 010/011 → illegal.
  - JAL 1101111: ADD, use_pc=1, use_imm=1, J-type immediate.
  - JALR 1100111: ADD, use_imm=1, I-type immediate; requires funct3=000.
  - Any other opcode → illegal.
- Illegal words:
  - Still flow through the buffer.
  - Carry out_illegal=1, alu_ctrl=0, use_imm=0, use_pc=0, imm=0.
- Immediates are sign-extended from instr[31] unless stated otherwise above.

Test Plan:
- 0x002081B3 (add x3,x1,x2) with out_ready=1 → next cycle: out_valid=1, alu_ctrl=0, use_imm=0, illegal=0. 0x402081B3 → alu_ctrl=1.
- 0x40315093 (srai x1,x2,3) → alu_ctrl=8, use_imm=1, imm=0x00000003. 0x123452B7 (lui) → alu_ctrl=10, imm=0x12345000.
- 0x0020E463 (bltu x1,x2,+8) → alu_ctrl=9, imm=0x00000008, use_imm=0. 0xFFFFFFFF → illegal=1, alu_ctrl=0.
- Back-pressure: hold out_ready=0 and present three words A, B, C → A and B accepted, then in_ready=0 and C stalls. Outputs hold A stable. Release out_ready → A, B, C emerge in order on consecutive cycles with no loss or duplication.
- Buffer FULL, assert flush together with in_valid → next cycle out_valid=0 and in_ready=1; the flushed word never appears.
- Assert rst asynchronously mid-stream, between clock edges → out_valid falls immediately, in_ready=1, data outputs 0. The first word after reset is decoded normally.
- With EN_SKID=0 and out_ready toggling every cycle → in_ready = !out_valid || out_ready, and throughput is 1 word/cycle whenever out_ready=1.
